if_id_stage: RTL

//  Fetch stage plus IF/ID pipeline register of the MIPS pipeline; sits directly upstream of the hazard unit.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/if_fetch_ctrl.sv | 50 +++++
 rtl/if_id_stage.sv | 78 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and fetch state encoding
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int REG_FIELD_W = 5;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN} fetch_state_e;
endpackage

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch FSM, request address register and hold buffer of the IF stage
module if_fetch_ctrl
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               advance,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_next,
  output fetch_state_e       state,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [INSTR_W-1:0] hold_buf
);
  fetch_state_e state_nxt;
  logic new_req;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_BOOT;
    else state <= state_nxt;
  // Next state; a flush never abandons a live handshake, it drains it instead
  always_comb begin
    state_nxt = state;
    imem_req = 1'b0;
    new_req = 1'b0;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: state_nxt = flush ? (imem_ack ? S_FETCH : S_DRAIN) : (imem_ack && !advance) ? S_HOLD : S_FETCH;
      S_HOLD:  state_nxt = (flush || advance) ? S_FETCH : S_HOLD;
      S_DRAIN: state_nxt = imem_ack ? S_FETCH : S_DRAIN;
      default: state_nxt = S_BOOT;
    endcase
    imem_req = state == S_FETCH || state == S_DRAIN;
    new_req = state_nxt == S_FETCH && (state != S_FETCH || imem_ack);
  end
  // Request address captures the upcoming PC when a request starts; acked word is buffered for stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_addr <= '0;
      hold_buf <= '0;
    end else begin
      if (new_req) req_addr <= pc_next;
      if (state == S_FETCH && imem_ack) hold_buf <= imem_rdata;
    end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC, instruction fetch handshake and IF/ID register; IF_STALL_CNT_EN adds stall_cnt
module if_id_stage
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_write,
  input  logic                   ifid_write,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      branch_target,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic [INSTR_W-1:0]     ifid_instr,
  output logic [ADDR_W-1:0]      ifid_pc4,
  output logic                   ifid_valid,
  output logic [REG_FIELD_W-1:0] ifid_rs,
  output logic [REG_FIELD_W-1:0] ifid_rt
`ifdef IF_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);
  fetch_state_e state;
  logic [ADDR_W-1:0] pc, pc_next, req_addr;
  logic [INSTR_W-1:0] hold_buf;
  logic advance, load_word, bubble;
  assign advance = pc_write & ifid_write;
  assign load_word = advance && ((state == S_FETCH && imem_ack) || state == S_HOLD);
  assign bubble = flush || (state == S_FETCH && !imem_ack && ifid_write);
  assign pc_next = flush ? branch_target : load_word ? pc + ADDR_W'(4) : pc;
  assign imem_addr = req_addr;
  assign ifid_rs = ifid_instr[RS_LSB +: REG_FIELD_W];
  assign ifid_rt = ifid_instr[RT_LSB +: REG_FIELD_W];
  if_fetch_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_ctrl (
    .clk(clk),
    .rst_n(rst_n),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .advance(advance),
    .flush(flush),
    .pc_next(pc_next),
    .state(state),
    .imem_req(imem_req),
    .req_addr(req_addr),
    .hold_buf(hold_buf)
  );
  // Program counter: redirect on flush, step past each word handed to IF/ID
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else pc <= pc_next;
  // IF/ID register: bubbles take priority over loads; stalls simply hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ifid_instr <= INSTR_W'(NOP_INSTR);
      ifid_pc4 <= '0;
      ifid_valid <= 1'b0;
    end else if (bubble) begin
      ifid_instr <= INSTR_W'(NOP_INSTR);
      ifid_valid <= 1'b0;
    end else if (load_word) begin
      ifid_instr <= state == S_FETCH ? imem_rdata : hold_buf;
      ifid_pc4 <= req_addr + ADDR_W'(4);
      ifid_valid <= 1'b1;
    end
`ifdef IF_STALL_CNT_EN
  // Saturating count of cycles where IF/ID was held by the hazard unit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (!ifid_write && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
`endif
endmodule
